// File: rtl/fft2d_pkg.sv
// Shared constants and FSM state encoding for the FFT2D streaming front end.
package fft2d_pkg;

  localparam int unsigned FRAME_LEN = 1024;
  localparam int unsigned SAMPLE_W  = 19;
  localparam int unsigned WORD_W    = 38;
  localparam int unsigned CNT_W     = 10;

  typedef enum logic [2:0] {
    IDLE,
    PREFETCH,
    SEND,
    WAIT,
    RECV,
    FIN
  } state_t;

endpackage

// File: rtl/fft2d_watchdog.sv
// Result-phase watchdog: counts stalled cycles, flags when TIMEOUT_CYC is reached.
// Only instantiated when FFT2D_STREAM_TX_TIMEOUT_EN is defined.
module fft2d_watchdog #(
  parameter int unsigned TIMEOUT_CYC = 32767
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic expired
);

  logic [15:0] cnt;

  // Stall counter: cleared by any result beat or outside the result phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (run)
      cnt <= cnt + 16'd1;
  end

  // Fires in the TIMEOUT_CYC-th consecutive stalled cycle.
  assign expired = run && (cnt == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/fft2d_stream_tx.sv
// Streams one 1024-sample frame from SRAM into the FFT2D and writes the
// 1024 results back. Optional watchdog: define FFT2D_STREAM_TX_TIMEOUT_EN.
module fft2d_stream_tx
  import fft2d_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 32767
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       mode_in,
  input  logic                       src_bank,
  input  logic                       dst_bank,
  output logic [10:0]                mem_a,
  output logic                       mem_wen,
  output logic [WORD_W-1:0]          mem_d,
  input  logic [WORD_W-1:0]          mem_q,
  output logic                       IN_VALID,
  output logic                       MODE,
  output logic signed [SAMPLE_W-1:0] FFT2D_IN_R,
  output logic signed [SAMPLE_W-1:0] FFT2D_IN_I,
  input  logic                       OUT_VALID,
  input  logic signed [SAMPLE_W-1:0] FFT2D_OUT_R,
  input  logic signed [SAMPLE_W-1:0] FFT2D_OUT_I,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_LEN - 1);

  state_t           state, state_nxt;
  logic             mode_q, src_q, dst_q;
  logic [CNT_W-1:0] scnt, rcnt;
  logic             timeout;
  logic             in_result;

  assign in_result = (state == WAIT) || (state == RECV);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next state and SRAM port; result writes are combinational with OUT_VALID.
  always_comb begin
    state_nxt = state;
    mem_a     = '0;
    mem_wen   = 1'b1;
    mem_d     = '0;
    case (state)
      IDLE:     if (start) state_nxt = PREFETCH;
      PREFETCH: begin
        mem_a     = {src_q, 10'd0};
        state_nxt = SEND;
      end
      // Read address runs one ahead of the sample being registered out.
      SEND: begin
        mem_a = {src_q, CNT_W'(scnt + 1'b1)};
        if (scnt == LAST) state_nxt = WAIT;
      end
      WAIT, RECV: begin
        if (OUT_VALID) begin
          mem_wen   = 1'b0;
          mem_a     = {dst_q, rcnt};
          mem_d     = {FFT2D_OUT_R, FFT2D_OUT_I};
          state_nxt = (rcnt == LAST) ? FIN : RECV;
        end else if (timeout) begin
          state_nxt = FIN;
        end
      end
      FIN:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Frame fields and sample/result counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
      src_q  <= 1'b0;
      dst_q  <= 1'b0;
      scnt   <= '0;
      rcnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mode_q <= mode_in;
          src_q  <= src_bank;
          dst_q  <= dst_bank;
          scnt   <= '0;
          rcnt   <= '0;
        end
        SEND:       scnt <= scnt + 1'b1;
        WAIT, RECV: if (OUT_VALID) rcnt <= rcnt + 1'b1;
        default:    ;
      endcase
    end
  end

  // Registered sample stage toward the FFT2D; zero outside valid beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IN_VALID   <= 1'b0;
      MODE       <= 1'b0;
      FFT2D_IN_R <= '0;
      FFT2D_IN_I <= '0;
    end else begin
      IN_VALID   <= (state == SEND);
      MODE       <= (state == SEND) && (scnt == '0) && mode_q;
      FFT2D_IN_R <= (state == SEND) ? mem_q[WORD_W-1:SAMPLE_W] : '0;
      FFT2D_IN_I <= (state == SEND) ? mem_q[SAMPLE_W-1:0] : '0;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

`ifdef FFT2D_STREAM_TX_TIMEOUT_EN
  logic err_q;

  fft2d_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .run     ((state == WAIT) || ((state == RECV) && !OUT_VALID)),
    .clr     (!in_result || OUT_VALID),
    .expired (timeout)
  );

  // Sticky timeout flag, cleared only by the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if ((state == IDLE) && start)
      err_q <= 1'b0;
    else if (in_result && !OUT_VALID && timeout)
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: doc/fft2d_stream_tx.md
FFT2D_STREAM_TX -- requirements
Module: fft2d_stream_tx

Interface
REQ-001 Parameter: TIMEOUT_CYC, default 32767; the maximum number of cycles allowed from the last IN_VALID until the first OUT_VALID, and between OUT_VALID beats.
REQ-002 Port: clk, input, 1 bit; the clock.
REQ-003 Port: rst_n, input, 1 bit; reset, asynchronous, active-low.
REQ-004 Port: start, input, 1 bit; one-cycle frame launch request.
REQ-005 Port: mode_in, input, 1 bit; frame MODE, latched when start is accepted.
REQ-006 Port: src_bank, input, 1 bit; source half of memory (address bit 10), latched at start.
REQ-007 Port: dst_bank, input, 1 bit; result half of memory, latched at start.
REQ-008 Port: mem_a, output, 11 bits; single-port SRAM address.
REQ-009 Port: mem_wen, output, 1 bit; SRAM write enable, 0 = write, 1 = read.
REQ-010 Port: mem_d, output, 38 bits; SRAM write data, real part in [37:19], imaginary part in [18:0].
REQ-011 Port: mem_q, input, 38 bits; SRAM read data, valid one cycle after its address.
REQ-012 Port: IN_VALID, output, 1 bit; sample strobe to the FFT2D.
REQ-013 Port: MODE, output, 1 bit; mode to the FFT2D.
REQ-014 Port: FFT2D_IN_R and FFT2D_IN_I, output, signed 19 bits each; sample to the FFT2D.
REQ-015 Port: OUT_VALID, input, 1 bit; result strobe from the FFT2D.
REQ-016 Port: FFT2D_OUT_R and FFT2D_OUT_I, input, signed 19 bits each; result sample from the FFT2D.
REQ-017 Port: busy, output, 1 bit; high in every state except IDLE.
REQ-018 Port: done, output, 1 bit; one-cycle frame-complete pulse.
REQ-019 Port: err, output, 1 bit; timeout flag.

Function
REQ-020 The FSM SHALL have the states IDLE, PREFETCH, SEND, WAIT, RECV and FIN.
REQ-021 In IDLE, start = 1 SHALL latch mode_in, src_bank and dst_bank, clear the counters, and enter PREFETCH.
REQ-022 start SHALL be ignored whenever busy = 1.
REQ-023 PREFETCH SHALL last one cycle with mem_a = {src_bank, 10'd0} and mem_wen = 1.
REQ-024 In SEND, mem_a SHALL advance by one per cycle, and each mem_q SHALL be registered onto FFT2D_IN_R = mem_q[37:19] and FFT2D_IN_I = mem_q[18:0].
REQ-025 IN_VALID SHALL first rise exactly 2 cycles after the cycle in which start is sampled.
REQ-026 IN_VALID SHALL stay high for exactly 1024 consecutive cycles, and sample k SHALL be the word at address {src_bank, k}.
REQ-027 MODE SHALL equal the latched mode only in the first IN_VALID cycle, and SHALL be 0 otherwise.
REQ-028 When IN_VALID = 0, FFT2D_IN_R and FFT2D_IN_I SHALL be 0.
REQ-029 After the 1024th sample, IN_VALID SHALL fall and the FSM SHALL enter WAIT.
REQ-030 In WAIT, OUT_VALID = 1 SHALL enter RECV, and that same beat SHALL be written as result 0.
REQ-031 Each OUT_VALID = 1 cycle in WAIT or RECV SHALL write one result combinationally: mem_wen = 0, mem_a = {dst_bank, rcnt}, mem_d = {FFT2D_OUT_R, FFT2D_OUT_I}, rcnt = rcnt + 1.
REQ-032 If OUT_VALID drops before 1024 beats, the FSM SHALL hold rcnt and stay in RECV; it SHALL NOT write while OUT_VALID = 0 (mem_wen = 1).
REQ-033 After the 1024th write, the FSM SHALL enter FIN, pulse done for one cycle, and return to IDLE.
REQ-034 A start pulse in the FIN cycle SHALL be ignored.
REQ-035 OUT_VALID SHALL be ignored in IDLE, PREFETCH and SEND.
REQ-036 Counters SHALL be 10 bits, terminating at 1023.
REQ-037 Data SHALL pass through unmodified: no saturation and no sign handling.

Reset
REQ-038 On rst_n = 0, the FSM SHALL go to IDLE and all counters and latched fields SHALL be cleared to 0.
REQ-039 On reset: IN_VALID = 0, MODE = 0, FFT2D_IN_R = 0, FFT2D_IN_I = 0, busy = 0, done = 0, err = 0.
REQ-040 On reset: mem_wen = 1, mem_a = 0, mem_d = 0.
REQ-041 A reset during any state SHALL abort the frame with no further SRAM write.

Configuration
REQ-042 With FFT2D_STREAM_TX_TIMEOUT_EN defined, a 16-bit watchdog SHALL count the cycles spent in WAIT, and in RECV with OUT_VALID = 0, and SHALL clear on each OUT_VALID beat.
REQ-043 With the macro defined, when the watchdog reaches TIMEOUT_CYC, the block SHALL set err, pulse done, and enter IDLE.
REQ-044 err SHALL be sticky until the next accepted start.
REQ-045 Without the macro, no watchdog SHALL exist, err SHALL be tied to 0, and WAIT and RECV SHALL be unbounded.

Structure
REQ-046 The shared package fft2d_pkg SHALL hold FRAME_LEN = 1024, SAMPLE_W = 19, WORD_W = 38, and the FSM state encoding.
REQ-047 The watchdog SHALL be a sub-module, fft2d_watchdog, instantiated only under FFT2D_STREAM_TX_TIMEOUT_EN.
REQ-048 All other logic SHALL be inline.

Verification
REQ-049 Ramp test: memory words {k, -k} at addresses 0..1023, start with mode_in = 0 and src_bank = 0 at cycle 10 -> IN_VALID high in cycles 12..1035, MODE = 1 nowhere, sample k = (k, -k).
REQ-050 Mode test: start with mode_in = 1 -> MODE = 1 only in cycle 12, then 0.
REQ-051 Result capture: dst_bank = 1, OUT_VALID driven for 1024 cycles, with 5 idle gaps inserted at beat 500 -> the words at addresses 1024..2047 equal the driven sequence; exactly 1024 writes; done pulses once, one cycle after the last beat.
REQ-052 Start while busy: start pulsed during SEND and again in the FIN cycle -> no restart, and IN_VALID stays contiguous.
REQ-053 Reset mid-frame: rst_n = 0 at SEND sample 300 -> IN_VALID = 0 immediately, busy = 0, no SRAM write; a new start afterwards behaves as in REQ-049.
REQ-054 Timeout (macro defined, TIMEOUT_CYC = 100): OUT_VALID is never driven -> err = 1 and done pulses 100 cycles after entering WAIT; the next start clears err.
